// File: rtl/shared_mem_rr.sv
// shared_mem_rr
//   Word-addressed 32-bit RAM shared by NUM_CORES cores through a
//   round-robin arbiter. Each core can read, write, or fetch-and-add one word
//   per request. At most one operation commits per cycle, so fetch-and-add is
//   atomic.
//
// Handshake (req/ack):
//   A core raises req[c] and holds req/op/addr/wdata stable until ack[c]
//   pulses. ack[c] is high for exactly one cycle, one cycle after the grant.
//   err[c] and rdata[c] are valid together with ack[c]. rdata[c] then holds
//   until that core's next ack. A core whose ack is high is not eligible for
//   grant in that cycle, so a req left high after completion is never
//   serviced twice.
//
// Ports:
//   clk      in   system clock; all state updates on posedge
//   reset    in   synchronous active-high reset (also re-initialises the RAM)
//   req      in   [NUM_CORES]     per-core request
//   op       in   [2*NUM_CORES]   00 read, 01 write, 10 fetch-add, 11 read
//   addr     in   [32*NUM_CORES]  per-core byte address
//   wdata    in   [32*NUM_CORES]  per-core write data / add operand
//   ack      out  [NUM_CORES]     one-cycle completion pulse
//   err      out  [NUM_CORES]     address miss or unaligned (valid with ack)
//   rdata    out  [32*NUM_CORES]  registered per-core read data
//   dbg_addr in   [DEPTH_LOG2]    debug word index
//   dbg_data out  [32]            combinational mem[dbg_addr]
module shared_mem_rr #(
  parameter int NUM_CORES    = 4,
  parameter int DEPTH_LOG2   = 5,
  parameter int BASE_ADDRESS = 0,
  parameter int INIT_BASE    = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CORES-1:0]    req,
  input  logic [2*NUM_CORES-1:0]  op,
  input  logic [32*NUM_CORES-1:0] addr,
  input  logic [32*NUM_CORES-1:0] wdata,
  output logic [NUM_CORES-1:0]    ack,
  output logic [NUM_CORES-1:0]    err,
  output logic [32*NUM_CORES-1:0] rdata,
  input  logic [DEPTH_LOG2-1:0]   dbg_addr,
  output logic [31:0]             dbg_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int TAG_W = 30 - DEPTH_LOG2;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FADD  = 2'b10;

  logic [31:0]          r_mem   [DEPTH];
  logic [31:0]          r_rdata [NUM_CORES];
  logic [NUM_CORES-1:0] r_ack;
  logic [NUM_CORES-1:0] r_err;
  logic [PTR_W-1:0]     r_ptr;

  logic [NUM_CORES-1:0]  w_elig;
  logic                  w_gnt_vld;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [1:0]            w_op;
  logic [31:0]           w_addr;
  logic [31:0]           w_wdata;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_hit;
  logic [31:0]           w_old;

  // A core completing this cycle still has its stale req high; mask it out.
  assign w_elig = req & ~r_ack;

  // Round-robin search upward from r_ptr. The loop runs from the farthest
  // candidate down, so the nearest eligible core is the last one written.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (w_elig[PTR_W'((int'(r_ptr) + k) % NUM_CORES)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PTR_W'((int'(r_ptr) + k) % NUM_CORES);
      end
    end
  end

  assign w_op    = op[int'(w_gnt_idx) * 2 +: 2];
  assign w_addr  = addr[int'(w_gnt_idx) * 32 +: 32];
  assign w_wdata = wdata[int'(w_gnt_idx) * 32 +: 32];
  assign w_idx   = w_addr[DEPTH_LOG2+1:2];
  assign w_hit   = (w_addr[31:DEPTH_LOG2+2] == TAG_W'(BASE_ADDRESS)) &&
                   (w_addr[1:0] == 2'b00);
  assign w_old   = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      r_ack <= '0;
      r_err <= '0;
      for (int i = 0; i < NUM_CORES; i++) r_rdata[i] <= '0;
      for (int i = 0; i < DEPTH; i++)     r_mem[i]   <= 32'(INIT_BASE + i);
    end else begin
      r_ack <= '0;
      r_err <= '0;
      if (w_gnt_vld) begin
        r_ack[w_gnt_idx] <= 1'b1;
        r_ptr            <= PTR_W'((int'(w_gnt_idx) + 1) % NUM_CORES);
        if (w_hit) begin
          case (w_op)
            OP_WRITE: begin
              r_mem[w_idx]       <= w_wdata;
              r_rdata[w_gnt_idx] <= w_wdata;
            end
            OP_FADD: begin
              // Returns the old value; the sum wraps modulo 2**32.
              r_mem[w_idx]       <= w_old + w_wdata;
              r_rdata[w_gnt_idx] <= w_old;
            end
            default: r_rdata[w_gnt_idx] <= w_old;
          endcase
        end else begin
          // Misses and unaligned accesses complete normally but touch nothing.
          r_err[w_gnt_idx]   <= 1'b1;
          r_rdata[w_gnt_idx] <= '0;
        end
      end
    end
  end

  assign ack      = r_ack;
  assign err      = r_err;
  assign dbg_data = r_mem[dbg_addr];

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_rdata
    assign rdata[g*32 +: 32] = r_rdata[g];
  end

endmodule

// File: doc/shared_mem_rr.md
Name: shared_mem_rr

Overview:
- Parametrised multi-core shared data memory for the single-cycle manycore.
- Up to NUM_CORES cores share one word-addressed RAM through a round-robin arbiter with a request/acknowledge handshake.
- Supports read, write and atomic fetch-and-add, so cores can synchronise and accumulate partial results without software locks.
- Sits between the per-core data-memory address decode and the shared region; a combinational debug port exposes any word to the testbench.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- DEPTH_LOG2, 5, log2 of word count; memory holds 2**DEPTH_LOG2 32-bit words.
- BASE_ADDRESS, 0, value that address[31:DEPTH_LOG2+2] must match for a request to hit this memory.
- INIT_BASE, 100, word i is loaded with INIT_BASE+i on reset.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_CORES  per-core request, held high until acked.
- op  in  2*NUM_CORES  per-core operation: 00 read, 01 write, 10 fetch-add, 11 reserved (treated as read).
- addr  in  32*NUM_CORES  per-core byte address.
- wdata  in  32*NUM_CORES  per-core write data or add operand.
- ack  out  NUM_CORES  one-cycle pulse: request completed.
- err  out  NUM_CORES  valid with ack: address miss or unaligned address.
- rdata  out  32*NUM_CORES  registered per-core read data, valid with ack and held until that core's next ack.
- dbg_addr  in  DEPTH_LOG2  debug word index.
- dbg_data  out  32  combinational mem[dbg_addr].

Behaviour:
- Reset: ack=0, err=0, all rdata=0, round-robin pointer=0, mem[i]=INIT_BASE+i for every i.
- Reset takes priority over everything. Requests pending when reset is asserted are dropped with no ack; the core must re-request.
- Arbitration:
  - Each cycle, at most one core is granted: the first core with req=1 and ack=0 this cycle, searching upward (wrapping) from the pointer.
  - After a grant to core g, the pointer becomes (g+1) mod NUM_CORES. With no requests, the pointer holds.
- Latency and handshake:
  - Grant in cycle t; at posedge t+1 the memory op commits and ack[g] pulses high for exactly one cycle.
  - Core must hold req/op/addr/wdata stable until it sees ack, then may drop req or present a new request in the next cycle.
  - A core whose ack is high in a cycle is not eligible for grant in that cycle. This prevents a double-service of a stale req.
- Address handling:
  - Word index = addr[DEPTH_LOG2+1:2].
  - Hit requires addr[31:DEPTH_LOG2+2]==BASE_ADDRESS and addr[1:0]==0.
  - A miss or unaligned request is still granted and acked in the normal slot with err=1. Memory is not modified and rdata is set to 0.
- Operations (on a hit):
  - read: rdata <= mem[idx].
  - write: mem[idx] <= wdata; rdata <= wdata.
  - fetch-add: rdata <= old mem[idx]; mem[idx] <= old + wdata, modulo 2**32 (wraps, no overflow flag).
  - Fetch-add is atomic by construction because only one op commits per cycle.
- Debug port: dbg_data is read combinationally and reflects a write on the cycle after its commit edge.
- Fairness: with all cores continuously requesting, each core is acked exactly once every NUM_CORES cycles. Maximum wait for any core is NUM_CORES cycles.

Test Plan:
- Reset then dbg sweep: dbg_addr 0..31 -> dbg_data 100..131. Hold reset with core 0 requesting -> ack stays 0.
- Core 1 writes 0xDEADBEEF to byte addr 0x1C, then reads 0x1C -> each acked one cycle after grant; read rdata[1]=0xDEADBEEF, err=0.
- All 4 cores request read of addr 0 in the same cycle -> acks in order core0, core1, core2, core3 on consecutive cycles; each rdata=100.
- All 4 cores fetch-add 5 to addr 0x0C (init 103) -> returned values are 103, 108, 113, 118 in grant order; final dbg_data[3]=123.
- Fetch-add of 1 to a word preloaded with 0xFFFFFFFF -> rdata=0xFFFFFFFF, word becomes 0x00000000.
- Core 2 reads addr 0x80 (miss) and core 3 reads addr 0x06 (unaligned) -> both acked with err=1, rdata=0, memory unchanged. Reset asserted mid-burst -> pointer returns to 0 and pending requests get no ack.
